// File: rtl/mc_datapath.sv
// mc_datapath: multicycle MIPS-subset core (datapath + FSM controller).
// One memory port carries both instruction fetch and data accesses; every
// access is a req/ready handshake and may take any number of wait states.
// Ports:
//   i_clk         rising-edge clock
//   i_reset       synchronous active-high reset
//   o_mem_req     memory access request
//   o_mem_we      write strobe, meaningful only with o_mem_req
//   o_mem_addr    byte address
//   o_mem_wdata   store data
//   i_mem_rdata   read data, sampled on a req & ready cycle
//   i_mem_ready   access completes on a req & ready cycle
//   o_pc          current program counter
//   o_state       FSM state encoding
//   o_halted      sticky, set on entering the halt state
module mc_datapath #(
  parameter int unsigned    n        = 32,
  parameter logic [n-1:0]   RESET_PC = '0,
  parameter int unsigned    RA_REG   = 31
) (
  input  logic         i_clk,
  input  logic         i_reset,
  output logic         o_mem_req,
  output logic         o_mem_we,
  output logic [n-1:0] o_mem_addr,
  output logic [n-1:0] o_mem_wdata,
  input  logic [n-1:0] i_mem_rdata,
  input  logic         i_mem_ready,
  output logic [n-1:0] o_pc,
  output logic [3:0]   o_state,
  output logic         o_halted
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11,
    StJal    = 4'd12,
    StHalt   = 4'd15
  } state_e;

  localparam logic [5:0]   OpRtype = 6'h00;
  localparam logic [5:0]   OpJ     = 6'h02;
  localparam logic [5:0]   OpJal   = 6'h03;
  localparam logic [5:0]   OpBeq   = 6'h04;
  localparam logic [5:0]   OpAddi  = 6'h08;
  localparam logic [5:0]   OpLw    = 6'h23;
  localparam logic [5:0]   OpSw    = 6'h2B;
  localparam logic [4:0]   RaAddr  = 5'(RA_REG);
  localparam logic [n-1:0] PcStep  = n'(4);

  // Architectural and inter-cycle registers
  state_e       r_state;
  logic [n-1:0] r_pc;
  logic         r_halted;
  logic [31:0]  r_ir;
  logic [n-1:0] r_a;
  logic [n-1:0] r_b;
  logic [n-1:0] r_aluout;
  logic [n-1:0] r_mdr;
  logic [n-1:0] r_rf [32];

  // Instruction fields
  logic [5:0]   w_op;
  logic [4:0]   w_rs;
  logic [4:0]   w_rt;
  logic [4:0]   w_rd;
  logic [5:0]   w_funct;
  logic         w_unused_shamt;

  assign w_op           = r_ir[31:26];
  assign w_rs           = r_ir[25:21];
  assign w_rt           = r_ir[20:16];
  assign w_rd           = r_ir[15:11];
  assign w_funct        = r_ir[5:0];
  assign w_unused_shamt = ^r_ir[10:6];

  // Address arithmetic
  logic [n-1:0] w_simm;
  logic [n-1:0] w_branch_target;
  logic [n-1:0] w_jump_target;
  logic [n-1:0] w_addr_sum;

  assign w_simm          = {{(n-16){r_ir[15]}}, r_ir[15:0]};
  // r_pc already holds pc+4 once the fetch has completed
  assign w_branch_target = r_pc + (w_simm << 2);
  assign w_jump_target   = {r_pc[n-1:28], r_ir[25:0], 2'b00};
  assign w_addr_sum      = r_a + w_simm;

  // Register file read ports, r0 hard-wired to zero
  logic [n-1:0] w_rf_rs;
  logic [n-1:0] w_rf_rt;

  assign w_rf_rs = (w_rs == 5'd0) ? '0 : r_rf[w_rs];
  assign w_rf_rt = (w_rt == 5'd0) ? '0 : r_rf[w_rt];

  // ALU control from funct, plus legality of the funct code
  logic [2:0]   w_alu_ctl;
  logic         w_funct_ok;
  logic [n-1:0] w_alu_y;

  always_comb begin
    w_alu_ctl  = 3'b010;
    w_funct_ok = 1'b1;
    case (w_funct)
      6'h20:   w_alu_ctl = 3'b010;
      6'h22:   w_alu_ctl = 3'b110;
      6'h24:   w_alu_ctl = 3'b000;
      6'h25:   w_alu_ctl = 3'b001;
      6'h2A:   w_alu_ctl = 3'b111;
      default: w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_y = '0;
    case (w_alu_ctl)
      3'b010:  w_alu_y = r_a + r_b;
      3'b110:  w_alu_y = r_a - r_b;
      3'b000:  w_alu_y = r_a & r_b;
      3'b001:  w_alu_y = r_a | r_b;
      3'b111:  w_alu_y = {{(n-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      default: w_alu_y = '0;
    endcase
  end

  // Next-state logic
  state_e w_state_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StFetch:  if (i_mem_ready) w_state_next = StDecode;
      StDecode: begin
        case (w_op)
          OpLw, OpSw: w_state_next = StMemAdr;
          OpRtype:    w_state_next = StExec;
          OpBeq:      w_state_next = StBranch;
          OpAddi:     w_state_next = StAddiEx;
          OpJ:        w_state_next = StJump;
          OpJal:      w_state_next = StJal;
          default:    w_state_next = StHalt;
        endcase
      end
      StMemAdr: w_state_next = (w_op == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (i_mem_ready) w_state_next = StMemWb;
      StMemWb:  w_state_next = StFetch;
      StMemWr:  if (i_mem_ready) w_state_next = StFetch;
      StExec:   w_state_next = w_funct_ok ? StAluWb : StHalt;
      StAluWb:  w_state_next = StFetch;
      StBranch: w_state_next = StFetch;
      StAddiEx: w_state_next = StAddiWb;
      StAddiWb: w_state_next = StFetch;
      StJump:   w_state_next = StFetch;
      StJal:    w_state_next = StFetch;
      StHalt:   w_state_next = StHalt;
      default:  w_state_next = StHalt;
    endcase
  end

  // Memory port; request is masked during reset so a pending access never completes
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = r_pc;
    o_mem_wdata = r_b;
    case (r_state)
      StFetch: o_mem_req = ~i_reset;
      StMemRd: begin
        o_mem_req  = ~i_reset;
        o_mem_addr = r_aluout;
      end
      StMemWr: begin
        o_mem_req  = ~i_reset;
        o_mem_we   = ~i_reset;
        o_mem_addr = r_aluout;
      end
      default: ;
    endcase
  end

  // Register file write port
  logic         w_rf_we;
  logic [4:0]   w_rf_waddr;
  logic [n-1:0] w_rf_wdata;

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = w_rt;
    w_rf_wdata = r_aluout;
    case (r_state)
      StMemWb: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = r_mdr;
      end
      StAluWb: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = w_rd;
      end
      StAddiWb: w_rf_we = 1'b1;
      StJal: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = RaAddr;
        w_rf_wdata = r_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_rf_we && (w_rf_waddr != 5'd0)) begin
      r_rf[w_rf_waddr] <= w_rf_wdata;
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= StFetch;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next == StHalt) r_halted <= 1'b1;
      case (r_state)
        StFetch: begin
          if (i_mem_ready) begin
            r_ir <= i_mem_rdata[31:0];
            r_pc <= r_pc + PcStep;
          end
        end
        StDecode: begin
          r_a      <= w_rf_rs;
          r_b      <= w_rf_rt;
          r_aluout <= w_branch_target;
        end
        StMemAdr, StAddiEx: r_aluout <= w_addr_sum;
        StMemRd:  if (i_mem_ready) r_mdr <= i_mem_rdata;
        StExec:   r_aluout <= w_alu_y;
        StBranch: if (r_a == r_b) r_pc <= r_aluout;
        StJump, StJal: r_pc <= w_jump_target;
        default: ;
      endcase
    end
  end

  assign o_pc     = r_pc;
  assign o_state  = r_state;
  assign o_halted = r_halted;

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath. A word-addressed memory model serves
// the shared port; expected stores are queued when each program is loaded
// and compared as the core completes them.
module tb_mc_datapath;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] pc;
  logic [3:0]  state;
  logic        halted;

  logic [31:0] mem [1024];
  logic [63:0] exp_q [$];
  int          n_pass;
  int          n_total;

  localparam logic [3:0] SFetch  = 4'd0;
  localparam logic [3:0] SDecode = 4'd1;
  localparam logic [3:0] SMemAdr = 4'd2;
  localparam logic [3:0] SMemWr  = 4'd5;
  localparam logic [3:0] SAddiEx = 4'd9;
  localparam logic [3:0] SAddiWb = 4'd10;
  localparam logic [3:0] SHalt   = 4'd15;
  localparam logic [31:0] Halt   = 32'hFC00_0000;

  mc_datapath #(.n(32), .RESET_PC(32'h0), .RA_REG(31)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_ready (mem_ready),
    .o_pc        (pc),
    .o_state     (state),
    .o_halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  // Scoreboard: compare every completed store with the oldest expectation
  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) begin
      logic [63:0] exp_st;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL store: unexpected addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        exp_st = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_st)
          $display("FAIL store: got addr=%h data=%h want addr=%h data=%h",
                   mem_addr, mem_wdata, exp_st[63:32], exp_st[31:0]);
        else n_pass++;
      end
      mem[mem_addr[11:2]] = mem_wdata;
    end
  end

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] idx);
    return {op, idx};
  endfunction

  // Enter reset and clear memory/scoreboard; caller then loads a program
  task automatic begin_reset();
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    exp_q.delete();
  endtask

  // Second reset edge, then release; returns inside the first post-reset cycle
  task automatic end_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_state(input logic [3:0] st, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (state == st) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Cycles until the core is in FETCH with pc == target
  task automatic wait_fetch_pc(input logic [31:0] target, input int max, output int cyc,
                               output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < max; i++) begin
      if (state == SFetch && pc == target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] seq [3];
    bit ok;
    seq[0] = SDecode; seq[1] = SAddiEx; seq[2] = SAddiWb;
    begin_reset();
    mem[0] = 32'h2001_0005;
    mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0080);
    exp_q.push_back({32'h80, 32'd5});
    n_total++;
    if ({mem_req, mem_we} !== 2'b00)
      $display("FAIL reset_req: got req/we=%b want 00", {mem_req, mem_we});
    else n_pass++;
    end_reset();
    n_total++;
    if ({state, pc, halted} !== {SFetch, 32'h0, 1'b0})
      $display("FAIL reset_state: got state=%0d pc=%h halted=%b want 0/0/0", state, pc, halted);
    else n_pass++;
    n_total++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h0})
      $display("FAIL first_fetch: got req=%b we=%b addr=%h want 1/0/0", mem_req, mem_we,
               mem_addr);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (state !== seq[i]) $display("FAIL addi_seq%0d: got %0d want %0d", i, state, seq[i]);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if ({state, pc} !== {SFetch, 32'h4})
      $display("FAIL addi_done: got state=%0d pc=%h want 0/4", state, pc);
    else n_pass++;
    wait_state(SHalt, 40, ok);
    n_total++;
    if (!ok || exp_q.size() != 0)
      $display("FAIL reset_prog_end: got halted=%b pending=%0d want 1/0", ok, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_wait_states();
    begin_reset();
    mem[0] = 32'h2001_0005;
    mem[1] = Halt;
    mem_ready = 1'b0;
    end_reset();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if ({mem_req, mem_addr, pc, state} !== {1'b1, 32'h0, 32'h0, SFetch})
        $display("FAIL wait_hold%0d: got req=%b addr=%h pc=%h state=%0d want 1/0/0/0", i,
                 mem_req, mem_addr, pc, state);
      else n_pass++;
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if ({state, pc} !== {SDecode, 32'h4})
      $display("FAIL wait_done: got state=%0d pc=%h want 1/4", state, pc);
    else n_pass++;
  endtask

  task automatic test_load_store();
    bit ok;
    int cyc;
    begin_reset();
    mem[0]  = 32'h2001_0005;                           // addi r1,r0,5
    mem[1]  = enc_j(6'h02, 26'd16);                    // j 0x40
    mem[16] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0008);      // sw r1,8(r0)
    mem[17] = enc_i(6'h23, 5'd0, 5'd2, 16'h0008);      // lw r2,8(r0)
    mem[18] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0084);      // sw r2,0x84(r0)
    mem[19] = Halt;
    exp_q.push_back({32'h8, 32'd5});
    exp_q.push_back({32'h84, 32'd5});
    end_reset();
    wait_state(SMemWr, 30, ok);
    n_total++;
    if ({ok, mem_req, mem_we, mem_addr, mem_wdata} !== {3'b111, 32'h8, 32'd5})
      $display("FAIL sw_port: got ok=%b req=%b we=%b addr=%h wdata=%h want 1/1/1/8/5", ok,
               mem_req, mem_we, mem_addr, mem_wdata);
    else n_pass++;
    wait_fetch_pc(32'h44, 10, cyc, ok);
    wait_fetch_pc(32'h48, 20, cyc, ok);
    n_total++;
    if (!ok || cyc != 5) $display("FAIL lw_latency: got ok=%b cycles=%0d want 5", ok, cyc);
    else n_pass++;
    wait_fetch_pc(32'h4C, 20, cyc, ok);
    n_total++;
    if (!ok || cyc != 4) $display("FAIL sw_latency: got ok=%b cycles=%0d want 4", ok, cyc);
    else n_pass++;
    wait_state(SHalt, 20, ok);
    n_total++;
    if (!ok || exp_q.size() != 0)
      $display("FAIL ls_end: got halted=%b pending=%0d want 1/0", ok, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_branch(input logic [4:0] rs, input logic [31:0] target);
    bit ok;
    int cyc;
    begin_reset();
    mem[0] = 32'h2001_0005;                            // addi r1,r0,5
    mem[1] = enc_i(6'h08, 5'd0, 5'd3, 16'd7);          // addi r3,r0,7
    mem[2] = enc_j(6'h02, 26'd4);                      // j 0x10
    mem[3] = Halt;
    mem[4] = enc_i(6'h04, rs, 5'd0, 16'd2);            // beq rs,r0,2
    for (int i = 5; i < 9; i++) mem[i] = Halt;
    end_reset();
    wait_fetch_pc(32'h8, 30, cyc, ok);
    wait_fetch_pc(32'h10, 10, cyc, ok);
    n_total++;
    if (!ok || cyc != 3) $display("FAIL j_latency: got ok=%b cycles=%0d want 3", ok, cyc);
    else n_pass++;
    wait_fetch_pc(target, 10, cyc, ok);
    n_total++;
    if (!ok || cyc != 3 || halted !== 1'b0)
      $display("FAIL beq_r%0d: got ok=%b cycles=%0d pc=%h want pc=%h in 3", rs, ok, cyc, pc,
               target);
    else n_pass++;
  endtask

  task automatic test_jal_alu();
    bit ok;
    int cyc;
    begin_reset();
    mem[0]  = 32'h2001_0005;                           // addi r1,r0,5
    mem[1]  = enc_i(6'h08, 5'd0, 5'd3, 16'd7);         // addi r3,r0,7
    mem[2]  = enc_j(6'h02, 26'd8);                     // j 0x20
    mem[8]  = enc_j(6'h03, 26'h40);                    // jal 0x100
    mem[64] = enc_i(6'h2B, 5'd0, 5'd31, 16'h0088);
    mem[65] = enc_r(5'd1, 5'd3, 5'd4, 6'h22);          // sub r4,r1,r3
    mem[66] = enc_i(6'h2B, 5'd0, 5'd4, 16'h008C);
    mem[67] = enc_r(5'd1, 5'd3, 5'd5, 6'h2A);          // slt r5,r1,r3
    mem[68] = enc_i(6'h2B, 5'd0, 5'd5, 16'h0090);
    mem[69] = enc_r(5'd4, 5'd1, 5'd5, 6'h2A);          // slt r5,r4,r1 (signed)
    mem[70] = enc_i(6'h2B, 5'd0, 5'd5, 16'h0094);
    mem[71] = enc_r(5'd1, 5'd1, 5'd0, 6'h20);          // add r0,r1,r1
    mem[72] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0098);
    mem[73] = enc_r(5'd1, 5'd3, 5'd6, 6'h24);          // and r6,r1,r3
    mem[74] = enc_i(6'h2B, 5'd0, 5'd6, 16'h009C);
    mem[75] = enc_r(5'd1, 5'd3, 5'd7, 6'h25);          // or r7,r1,r3
    mem[76] = enc_i(6'h2B, 5'd0, 5'd7, 16'h00A0);
    mem[77] = enc_i(6'h08, 5'd1, 5'd8, 16'hFFF0);      // addi r8,r1,-16
    mem[78] = enc_i(6'h2B, 5'd0, 5'd8, 16'h00A4);
    mem[79] = enc_r(5'd1, 5'd3, 5'd9, 6'h27);          // nor: unsupported funct
    exp_q.push_back({32'h88, 32'h24});
    exp_q.push_back({32'h8C, 32'hFFFF_FFFE});
    exp_q.push_back({32'h90, 32'd1});
    exp_q.push_back({32'h94, 32'd1});
    exp_q.push_back({32'h98, 32'd0});
    exp_q.push_back({32'h9C, 32'd5});
    exp_q.push_back({32'hA0, 32'd7});
    exp_q.push_back({32'hA4, 32'hFFFF_FFF5});
    end_reset();
    wait_fetch_pc(32'h20, 40, cyc, ok);
    wait_fetch_pc(32'h100, 10, cyc, ok);
    n_total++;
    if (!ok || cyc != 3) $display("FAIL jal_latency: got ok=%b cycles=%0d want 3", ok, cyc);
    else n_pass++;
    wait_fetch_pc(32'h104, 10, cyc, ok);
    wait_fetch_pc(32'h108, 10, cyc, ok);
    n_total++;
    if (!ok || cyc != 4) $display("FAIL rtype_latency: got ok=%b cycles=%0d want 4", ok, cyc);
    else n_pass++;
    wait_state(SHalt, 100, ok);
    n_total++;
    if (!ok || pc !== 32'h140 || exp_q.size() != 0)
      $display("FAIL alu_end: got halted=%b pc=%h pending=%0d want 1/140/0", ok, pc,
               exp_q.size());
    else n_pass++;
  endtask

  task automatic test_halt();
    int bad;
    begin_reset();
    mem[0] = Halt;
    end_reset();
    @(negedge clk);
    n_total++;
    if ({state, halted} !== {SDecode, 1'b0})
      $display("FAIL halt_pre: got state=%0d halted=%b want 1/0", state, halted);
    else n_pass++;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if ({state, halted, mem_req} !== {SHalt, 2'b10}) bad++;
      @(negedge clk);
    end
    n_total++;
    if (bad != 0) $display("FAIL halt_hold: got %0d bad cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    begin_reset();
    mem[0]  = 32'h2001_0005;
    mem[1]  = enc_i(6'h2B, 5'd0, 5'd1, 16'h0098);
    mem[38] = 32'hDEAD_BEEF;
    end_reset();
    wait_state(SMemAdr, 30, ok);
    mem_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if ({ok, state, mem_req} !== {1'b1, SMemWr, 1'b1})
      $display("FAIL mid_pending: got ok=%b state=%0d req=%b want 1/5/1", ok, state, mem_req);
    else n_pass++;
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    n_total++;
    if ({mem_req, mem_we} !== 2'b00)
      $display("FAIL mid_req_drop: got req/we=%b want 00", {mem_req, mem_we});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({state, pc, mem_req, mem[38]} !== {SFetch, 32'h0, 1'b0, 32'hDEAD_BEEF})
      $display("FAIL mid_reset: got state=%0d pc=%h req=%b mem=%h want 0/0/0/deadbeef", state,
               pc, mem_req, mem[38]);
    else n_pass++;
    reset = 1'b0;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b1;
    mem_ready = 1'b1;
    test_reset();
    test_wait_states();
    test_load_store();
    test_branch(5'd0, 32'h1C);
    test_branch(5'd1, 32'h14);
    test_jal_alu();
    test_halt();
    test_reset_mid_access();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1);
  end

endmodule
